// File: rtl/stream_arb_pkg.sv
// Shared types and arbitration helpers for the packet-level stream arbiter.
// Build option STREAM_ARB_FIXED_PRI_EN selects fixed priority instead of round-robin.
package stream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int MAX_NUM = 16;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Any requester present; pairs with the pick functions below.
  function automatic logic any_req(input logic [MAX_NUM-1:0] req);
    return |req;
  endfunction

  // First set bit searching upward from last+1, wrapping modulo num.
  function automatic int rr_pick(input logic [MAX_NUM-1:0] req,
                                 input int last,
                                 input int num);
    int   win;
    int   idx;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int i = 1; i <= MAX_NUM; i++) begin
      idx = (last + i) % num;
      if (!found && (i <= num) && req[idx[3:0]]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic int pri_pick(input logic [MAX_NUM-1:0] req,
                                  input int num);
    int   win;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_NUM; i++) begin
      if (!found && (i < num) && req[i[3:0]]) begin
        win   = i;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/stream_pipe_reg.sv
// One-deep valid/ready register slice; accepts a new word whenever it is
// empty or its current word is being taken in the same cycle.
module stream_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         vld_p1;
  logic [W-1:0] data_p1;
  logic         load_p0;

  assign in_ready = ~vld_p1 | out_ready;
  assign load_p0  = in_valid & in_ready;

  // p0 -> p1 boundary
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= load_p0 | (vld_p1 & ~out_ready);
      if (load_p0) begin
        data_p1 <= in_data;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked arbiter merging NUM valid/ready/last streams into one registered output.
// Define STREAM_ARB_FIXED_PRI_EN for lowest-index-wins arbitration instead of round-robin.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int NUM   = 4,
  parameter  int DSIZE = 24,
  localparam int IDW   = id_width(NUM)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NUM-1:0]       in_valid,
  output logic [NUM-1:0]       in_ready,
  input  logic [NUM*DSIZE-1:0] in_data,
  input  logic [NUM-1:0]       in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DSIZE-1:0]     out_data,
  output logic                 out_last,
  output logic [IDW-1:0]       out_id,
  output logic                 busy
);

  localparam int PW = DSIZE + 1 + IDW;

  arb_state_t       state;
  logic [IDW-1:0]   grant;
  logic             pipe_can_accept;
  logic             hs_p0;
  logic             any_p0;
  int               pick_p0;
  logic [DSIZE-1:0] lane [NUM];
  logic [DSIZE-1:0] sel_data_p0;
  logic             sel_last_p0;
  logic [PW-1:0]    pipe_d_p0;
  logic [PW-1:0]    pipe_q_p1;

`ifndef STREAM_ARB_FIXED_PRI_EN
  logic [IDW-1:0]   last_grant;
`endif

  for (genvar g = 0; g < NUM; g++) begin : g_lane
    assign lane[g] = in_data[g*DSIZE +: DSIZE];
  end

  assign any_p0 = any_req(MAX_NUM'(in_valid));

  always_comb begin
`ifdef STREAM_ARB_FIXED_PRI_EN
    pick_p0 = pri_pick(MAX_NUM'(in_valid), NUM);
`else
    pick_p0 = rr_pick(MAX_NUM'(in_valid), int'(last_grant), NUM);
`endif
  end

  assign sel_data_p0 = lane[grant];
  assign sel_last_p0 = in_last[grant];
  assign hs_p0       = (state == LOCK) & in_valid[grant] & pipe_can_accept;

  // Only the locked channel ever sees ready; the arbitration cycle shows none.
  always_comb begin
    in_ready = '0;
    if (state == LOCK) begin
      in_ready[grant] = pipe_can_accept;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
`ifndef STREAM_ARB_FIXED_PRI_EN
      last_grant <= IDW'(NUM - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_p0) begin
            grant <= IDW'(pick_p0);
            state <= LOCK;
          end
        end
        LOCK: begin
          if (hs_p0 && sel_last_p0) begin
`ifndef STREAM_ARB_FIXED_PRI_EN
            last_grant <= grant;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == LOCK);

  // p0 -> p1 boundary: granted beat plus its source id
  assign pipe_d_p0 = {grant, sel_last_p0, sel_data_p0};

  stream_pipe_reg #(
    .W (PW)
  ) u_pipe (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (hs_p0),
    .in_ready  (pipe_can_accept),
    .in_data   (pipe_d_p0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pipe_q_p1)
  );

  assign out_id   = pipe_q_p1[PW-1 -: IDW];
  assign out_last = pipe_q_p1[DSIZE];
  assign out_data = pipe_q_p1[DSIZE-1:0];

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: packet sources, an output collector and
// hand-written expected beat sequences including inter-packet spacing.
module tb_stream_rr_arbiter;

  localparam int NUM    = 4;
  localparam int DSIZE  = 24;
  localparam int IDW    = 2;
  localparam int DW_ALL = NUM * DSIZE;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM-1:0]    in_valid = '0;
  logic [NUM-1:0]    in_ready;
  logic [DW_ALL-1:0] in_data = '0;
  logic [NUM-1:0]    in_last = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DSIZE-1:0]  out_data;
  logic              out_last;
  logic [IDW-1:0]    out_id;
  logic              busy;

  stream_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] data;
    logic        last;
    logic [1:0]  id;
    int          gap;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit          src_act  [NUM];
  bit          src_gate [NUM];
  int          src_len  [NUM];
  int          src_idx  [NUM];
  int          src_pkts [NUM];
  logic [23:0] src_base [NUM];
  logic [NUM-1:0] hs_cap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    logic [NUM-1:0]    v;
    logic [NUM-1:0]    l;
    logic [DW_ALL-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < NUM; k++) begin
      if (src_act[2'(k)] && src_gate[2'(k)]) v[2'(k)] = 1'b1;
      if (src_act[2'(k)] && (src_idx[2'(k)] == src_len[2'(k)] - 1)) l[2'(k)] = 1'b1;
      d = d | (DW_ALL'(src_base[2'(k)] + 24'(src_idx[2'(k)])) << (k * DSIZE));
    end
    in_valid = v;
    in_last  = l;
    in_data  = d;
  endtask

  task automatic load(input int k, input logic [23:0] base, input int len, input int pkts);
    src_act[2'(k)]  = 1'b1;
    src_gate[2'(k)] = 1'b1;
    src_idx[2'(k)]  = 0;
    src_len[2'(k)]  = len;
    src_pkts[2'(k)] = pkts;
    src_base[2'(k)] = base;
    drive();
  endtask

  // One clock: sample handshakes at negedge, then advance sources after the edge.
  task automatic cycle();
    beat_t b;
    @(negedge clock);
    hs_cap = in_valid & in_ready;
    chk("ready_onehot", 64'($countones(in_ready) <= 1), 64'd1);
    if (out_valid && out_ready) begin
      b.data = out_data;
      b.last = out_last;
      b.id   = out_id;
      b.gap  = 0;
      b.cyc  = cyc;
      got_q.push_back(b);
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int k = 0; k < NUM; k++) begin
      if (hs_cap[2'(k)]) begin
        if (src_idx[2'(k)] == src_len[2'(k)] - 1) begin
          src_idx[2'(k)] = 0;
          if (src_pkts[2'(k)] > 0) begin
            src_pkts[2'(k)]--;
            src_base[2'(k)] = src_base[2'(k)] + 24'h000100;
          end else begin
            src_act[2'(k)] = 1'b0;
          end
        end else begin
          src_idx[2'(k)]++;
        end
      end
    end
    drive();
  endtask

  task automatic push_beat(input int id, input logic [23:0] data, input logic last, input int gap);
    beat_t b;
    b.data = data;
    b.last = last;
    b.id   = 2'(id);
    b.gap  = gap;
    b.cyc  = 0;
    exp_q.push_back(b);
  endtask

  task automatic push_pkt(input int id, input logic [23:0] base, input int len,
                          input int first_gap, input int inner_gap);
    for (int j = 0; j < len; j++) begin
      push_beat(id, base + 24'(j), (j == len - 1), (j == 0) ? first_gap : inner_gap);
    end
  endtask

  task automatic wait_idx(input int k, input int n, input string tag);
    int t;
    t = 0;
    while (src_idx[2'(k)] != n && t < 100) begin
      cycle();
      t++;
    end
    chk(tag, 64'(src_idx[2'(k)]), 64'(n));
  endtask

  task automatic drain(input string name);
    int n;
    int m;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      cycle();
      n++;
    end
    repeat (4) cycle();
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_beat%0d", name, i),
          64'({got_q[i].id, got_q[i].last, got_q[i].data}),
          64'({exp_q[i].id, exp_q[i].last, exp_q[i].data}));
      if (i > 0 && exp_q[i].gap != 0) begin
        chk($sformatf("%s_gap%0d", name, i),
            64'(got_q[i].cyc - got_q[i-1].cyc), 64'(exp_q[i].gap));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NUM; k++) begin
      src_act[2'(k)]  = 1'b0;
      src_gate[2'(k)] = 1'b1;
      src_idx[2'(k)]  = 0;
      src_len[2'(k)]  = 1;
      src_pkts[2'(k)] = 0;
      src_base[2'(k)] = '0;
    end
    drive();
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_out_id",    64'(out_id),    64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    rst_n = 1'b1;

    // All four requesters, 3-beat packets, requester 0 has two packets.
    load(0, 24'h000000, 3, 1);
    load(1, 24'h010000, 3, 0);
    load(2, 24'h020000, 3, 0);
    load(3, 24'h030000, 3, 0);
    #1;
    chk("t1_arb_ready", 64'(in_ready), 64'd0);
    chk("t1_arb_busy",  64'(busy),     64'd0);
    cycle();
    chk("t1_lock_busy",  64'(busy),     64'd1);
    chk("t1_lock_ready", 64'(in_ready), 64'b0001);
`ifdef STREAM_ARB_FIXED_PRI_EN
    push_pkt(0, 24'h000000, 3, 0, 1);
    push_pkt(0, 24'h000100, 3, 2, 1);
    push_pkt(1, 24'h010000, 3, 2, 1);
    push_pkt(2, 24'h020000, 3, 2, 1);
    push_pkt(3, 24'h030000, 3, 2, 1);
`else
    push_pkt(0, 24'h000000, 3, 0, 1);
    push_pkt(1, 24'h010000, 3, 2, 1);
    push_pkt(2, 24'h020000, 3, 2, 1);
    push_pkt(3, 24'h030000, 3, 2, 1);
    push_pkt(0, 24'h000100, 3, 2, 1);
`endif
    drain("t1");

    // Requester 2 packet; requester 0 arrives mid-packet and must wait.
    load(2, 24'h000010, 4, 0);
    push_pkt(2, 24'h000010, 4, 0, 1);
    wait_idx(2, 1, "t2_first_beat");
    load(0, 24'h000100, 2, 0);
    #1;
    chk("t2_r0_blocked", 64'(in_ready[0]), 64'd0);
    push_pkt(0, 24'h000100, 2, 2, 1);
    drain("t2");

    // Downstream stall in the middle of a packet.
    load(1, 24'h000020, 4, 0);
    push_pkt(1, 24'h000020, 4, 0, 0);
    for (int t = 0; t < 20 && !out_valid; t++) cycle();
    chk("t3_first_valid", 64'(out_valid), 64'd1);
    chk("t3_first_data",  64'(out_data),  64'h20);
    cycle();
    out_ready = 1'b0;
    #1;
    chk("t3_stall0_data",  64'(out_data),  64'h21);
    chk("t3_stall0_valid", 64'(out_valid), 64'd1);
    chk("t3_stall0_ready", 64'(in_ready),  64'd0);
    cycle();
    chk("t3_stall1_data",  64'(out_data),  64'h21);
    chk("t3_stall1_valid", 64'(out_valid), 64'd1);
    chk("t3_stall1_ready", 64'(in_ready),  64'd0);
    out_ready = 1'b1;
    drain("t3");

    // Granted requester goes quiet mid-packet; requester 1 must stay blocked.
    load(3, 24'h000030, 4, 0);
    push_pkt(3, 24'h000030, 4, 0, 0);
    wait_idx(3, 1, "t4_first_beat");
    src_gate[3] = 1'b0;
    load(1, 24'h000040, 1, 0);
    for (int t = 0; t < 3; t++) begin
      cycle();
      chk("t4_r1_blocked", 64'(in_ready[1]), 64'd0);
      chk("t4_busy",       64'(busy),        64'd1);
    end
    src_gate[3] = 1'b1;
    drive();
    push_pkt(1, 24'h000040, 1, 0, 0);
    drain("t4");

    // Reset lands in the middle of a 5-beat packet.
    load(2, 24'h000050, 5, 0);
    push_beat(2, 24'h000050, 1'b0, 0);
    wait_idx(2, 2, "t5_two_beats");
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_data",  64'(out_data),  64'd0);
    chk("t5_rst_id",    64'(out_id),    64'd0);
    chk("t5_rst_last",  64'(out_last),  64'd0);
    chk("t5_rst_busy",  64'(busy),      64'd0);
    chk("t5_rst_ready", 64'(in_ready),  64'd0);
    src_act[2] = 1'b0;
    src_idx[2] = 0;
    load(0, 24'h000060, 2, 0);
    load(3, 24'h000070, 1, 0);
    cycle();
    cycle();
    chk("t5_held_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    push_pkt(0, 24'h000060, 2, 0, 1);
    push_pkt(3, 24'h000070, 1, 2, 1);
    drain("t5");

    // Requesters 1 and 3 valid together; requester 1 keeps re-presenting packets.
    load(1, 24'h000080, 2, 2);
    load(3, 24'h000090, 2, 0);
`ifdef STREAM_ARB_FIXED_PRI_EN
    push_pkt(1, 24'h000080, 2, 0, 1);
    push_pkt(1, 24'h000180, 2, 2, 1);
    push_pkt(1, 24'h000280, 2, 2, 1);
    push_pkt(3, 24'h000090, 2, 2, 1);
`else
    push_pkt(1, 24'h000080, 2, 0, 1);
    push_pkt(3, 24'h000090, 2, 2, 1);
    push_pkt(1, 24'h000180, 2, 2, 1);
    push_pkt(1, 24'h000280, 2, 2, 1);
`endif
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
